// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: 32-step shift-add
// multiply or restoring divide, with pipeline stall control and flush abort.
module ex_muldiv_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_res
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div, sel_hi, neg_q;
  logic [31:0] hi_q, lo_q, b_q;

  // Operand decode for a newly accepted op
  logic        accept, op1_signed, op2_signed, op1_neg, op2_neg, neg_in;
  logic        in_div, in_sel_hi, fast_zero, fast_ovf, fast;
  logic [31:0] a_mag, b_mag, fast_res;

  always_comb begin
    accept     = (state != S_RUN) && i_start && !i_flush;
    in_div     = i_funct3[2];
    in_sel_hi  = in_div ? i_funct3[1] : (i_funct3 != 3'd0);
    op1_signed = (i_funct3 != 3'd3) && (i_funct3 != 3'd5) && (i_funct3 != 3'd7);
    op2_signed = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) ||
                 (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    op1_neg    = op1_signed && i_op1[31];
    op2_neg    = op2_signed && i_op2[31];
    // A remainder follows the dividend; everything else uses the product of signs.
    neg_in     = (in_div && i_funct3[1]) ? op1_neg : (op1_neg ^ op2_neg);
    a_mag      = op1_neg ? (32'd0 - i_op1) : i_op1;
    b_mag      = op2_neg ? (32'd0 - i_op2) : i_op2;
    fast_zero  = in_div && (i_op2 == 32'd0);
    fast_ovf   = in_div && !i_funct3[0] &&
                 (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
    fast       = fast_zero || fast_ovf;
    if (fast_zero) fast_res = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
    else           fast_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration of the shared datapath; hi/lo hold {acc,multiplier} or {rem,quot}
  logic [32:0] mul_sum, div_trial;
  logic [31:0] div_diff, hi_nxt, lo_nxt, div_sel, div_res, mul_res;
  logic        div_ok;
  logic [63:0] prod, prod_s;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : 32'd0)};
    div_trial = {hi_q, lo_q[31]};
    div_ok    = div_trial >= {1'b0, b_q};
    div_diff  = div_trial[31:0] - b_q;
    if (is_div) begin
      hi_nxt = div_ok ? div_diff : div_trial[31:0];
      lo_nxt = {lo_q[30:0], div_ok};
    end else begin
      hi_nxt = mul_sum[32:1];
      lo_nxt = {mul_sum[0], lo_q[31:1]};
    end
    prod    = {hi_nxt, lo_nxt};
    prod_s  = neg_q ? (64'd0 - prod) : prod;
    mul_res = sel_hi ? prod_s[63:32] : prod_s[31:0];
    div_sel = sel_hi ? hi_nxt : lo_nxt;
    div_res = neg_q ? (32'd0 - div_sel) : div_sel;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (accept) state_nxt = fast ? S_DONE : S_RUN;
        S_RUN:   if (cnt == 5'd0) state_nxt = S_DONE;
        S_DONE:  state_nxt = accept ? (fast ? S_DONE : S_RUN) : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign o_stall = !i_rst && (accept || (state == S_RUN && !i_flush));
  assign o_busy  = (state == S_RUN);
  assign o_done  = (state == S_DONE) && !i_flush && !i_rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      sel_hi <= 1'b0;
      neg_q  <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      b_q    <= 32'd0;
      o_res  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= 5'd31;
        is_div <= in_div;
        sel_hi <= in_sel_hi;
        neg_q  <= neg_in;
        hi_q   <= 32'd0;
        lo_q   <= in_div ? a_mag : b_mag;
        b_q    <= in_div ? b_mag : a_mag;
        if (fast) o_res <= fast_res;
      end else if (state == S_RUN && !i_flush) begin
        cnt  <= cnt - 5'd1;
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
        if (cnt == 5'd0) o_res <= is_div ? div_res : mul_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: expected results and completion cycles go
// into a scoreboard queue at issue and are checked when o_done fires.
module tb_ex_muldiv_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_flush;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1, i_op2;
  logic        o_stall, o_busy, o_done;
  logic [31:0] o_res;

  ex_muldiv_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_funct3(i_funct3),
    .i_op1(i_op1), .i_op2(i_op2), .i_flush(i_flush),
    .o_stall(o_stall), .o_busy(o_busy), .o_done(o_done), .o_res(o_res)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0, passed = 0, fails = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit fast);
    i_start  = 1'b1;
    i_funct3 = f3;
    i_op1    = a;
    i_op2    = b;
    sb.push_back('{res: exp, cyc: cyc + (fast ? 1 : 33)});
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) step();
    check("drain_timeout", 64'(sb.size()), 64'd0);
    step();
  endtask

  always @(negedge i_clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, o_done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {32'd0, o_res}, {32'd0, e.res});
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t normal[8];
  vec_t fastv[3];
  int   c0;

  initial begin
    normal[0] = '{3'd3, 32'd7,          32'hFFFF_FFFD, 32'h0000_0006};
    normal[1] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    normal[2] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    normal[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    normal[4] = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    normal[5] = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    normal[6] = '{3'd5, 32'd100,        32'd7,          32'd14};
    normal[7] = '{3'd7, 32'd100,        32'd7,          32'd2};
    fastv[0]  = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF};
    fastv[1]  = '{3'd6, 32'd5,          32'd0,          32'd5};
    fastv[2]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

    // Reset, with a start request that must not raise o_stall
    i_rst = 1'b1; i_start = 1'b1; i_flush = 1'b0;
    i_funct3 = 3'd0; i_op1 = 32'd1; i_op2 = 32'd1;
    step(); step();
    @(negedge i_clk);
    check("stall_in_reset", {63'd0, o_stall}, 64'd0);
    i_start = 1'b0;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("reset_done", {63'd0, o_done}, 64'd0);
    check("reset_busy", {63'd0, o_busy}, 64'd0);
    check("reset_res",  {32'd0, o_res},  64'd0);
    step();

    // MUL 7 x -3 with stall/busy profile across the full op
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    @(negedge i_clk);
    check("stall_cycle0", {63'd0, o_stall}, 64'd1);
    step();
    i_start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge i_clk);
      check("stall_run", {63'd0, o_stall}, 64'd1);
      check("busy_run",  {63'd0, o_busy},  64'd1);
      step();
    end
    @(negedge i_clk);
    check("stall_done", {63'd0, o_stall}, 64'd0);
    check("busy_done",  {63'd0, o_busy},  64'd0);
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(normal[i].f3, normal[i].a, normal[i].b, normal[i].exp, 1'b0);
      step();
      i_start = 1'b0;
      drain();
    end

    // Fast paths: done in cycle 1, never busy
    for (int i = 0; i < 3; i++) begin
      issue(fastv[i].f3, fastv[i].a, fastv[i].b, fastv[i].exp, 1'b1);
      @(negedge i_clk);
      check("fast_busy_c0", {63'd0, o_busy}, 64'd0);
      step();
      i_start = 1'b0;
      @(negedge i_clk);
      check("fast_busy_c1", {63'd0, o_busy}, 64'd0);
      drain();
    end

    // Flush in cycle 10 of a DIV, new MUL at cycle 12 finishing in cycle 45
    c0 = cyc;
    i_start = 1'b1; i_funct3 = 3'd4; i_op1 = 32'd1000; i_op2 = 32'd3;
    step();
    i_start = 1'b0;
    while (cyc < c0 + 10) step();
    i_flush = 1'b1;
    @(negedge i_clk);
    check("flush_stall", {63'd0, o_stall}, 64'd0);
    step();
    i_flush = 1'b0;
    @(negedge i_clk);
    check("flush_idle_busy", {63'd0, o_busy}, 64'd0);
    step();
    issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b0);
    step();
    i_start = 1'b0;
    drain();

    // Back-to-back: second start held into the DONE cycle
    c0 = cyc;
    issue(3'd0, 32'd3, 32'd4, 32'd12, 1'b0);
    step();
    i_start = 1'b0;
    while (cyc < c0 + 33) step();
    issue(3'd5, 32'd9, 32'd3, 32'd3, 1'b0);
    @(negedge i_clk);
    check("b2b_stall_in_done", {63'd0, o_stall}, 64'd1);
    step();
    i_start = 1'b0;
    drain();

    // Reset pulsed mid-RUN: op abandoned, no o_done, o_res cleared
    i_start = 1'b1; i_funct3 = 3'd0; i_op1 = 32'd3; i_op2 = 32'd4;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_mid_res",  {32'd0, o_res},  64'd0);
    check("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    check("rst_mid_done", {63'd0, o_done}, 64'd0);
    for (int k = 0; k < 40; k++) step();
    check("rst_mid_queue", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
